xnor_match_unit: RTL and testbench
==================================

XNOR_MATCH_UNIT -- requirements
Module: xnor_match_unit

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter WIDTH SHALL default to 8 and set the compared data width in bits (legal range 1..64).
REQ-003 Parameter CNT_W SHALL default to 8 and set the width of the consecutive-match run counter (legal range 1..16).
REQ-004 Parameter THRESH SHALL default to 3 and set the run length needed to lock (legal range 1..2^CNT_W-1).
REQ-005 Port clk SHALL be a 1-bit input: the rising-edge clock.
REQ-006 Port rst_n SHALL be a 1-bit input: asynchronous reset, active low.
REQ-007 Port cfg_load SHALL be a 1-bit input: a single-cycle pulse that captures cfg_pattern and cfg_mask.
REQ-008 Port cfg_pattern SHALL be a WIDTH-bit input: the reference pattern.
REQ-009 Port cfg_mask SHALL be a WIDTH-bit input: 1 means the bit is compared, 0 means don't-care.
REQ-010 Port in_valid SHALL be a 1-bit input: in_data is valid this cycle.
REQ-011 Port in_data SHALL be a WIDTH-bit input: the sample to compare.
REQ-012 Port out_valid SHALL be a 1-bit output: the result outputs are valid.
REQ-013 Port out_eq SHALL be a WIDTH-bit output: per-bit masked equality, ~(in_data^pattern) | ~mask.
REQ-014 Port out_match SHALL be a 1-bit output: AND-reduction of out_eq.
REQ-015 Port run_cnt SHALL be a CNT_W-bit output: the count of consecutive matches.
REQ-016 Port locked SHALL be a 1-bit output: high while the FSM is in LOCKED.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE (no pattern loaded), ARMED, and LOCKED.
REQ-018 In any state, cfg_load=1 SHALL capture pattern and mask, clear run_cnt to 0, and enter ARMED on the next edge.
REQ-019 In IDLE, in_valid SHALL be ignored: out_valid stays 0 and run_cnt stays 0.
REQ-020 In ARMED or LOCKED, with in_valid=1 and cfg_load=0, the block SHALL register out_eq, out_match and out_valid=1 on the next edge (latency 1 cycle).
REQ-021 When in_valid=0, out_valid SHALL be 0 on the next edge, and out_eq and out_match SHALL hold their last values.
REQ-022 If cfg_load and in_valid are both asserted in the same cycle, cfg_load SHALL win, the sample SHALL be dropped, and out_valid SHALL be 0 on the next edge.
REQ-023 A valid match SHALL increment run_cnt, saturating at 2^CNT_W-1 with no wrap-around.
REQ-024 A valid mismatch SHALL clear run_cnt to 0.
REQ-025 ARMED SHALL transition to LOCKED when a valid match makes the updated run_cnt >= THRESH; locked SHALL rise in the same cycle that out_valid reports that match.
REQ-026 LOCKED SHALL transition to ARMED on a valid mismatch, with locked falling in the same cycle as the out_match=0 report.
REQ-027 An all-zero mask SHALL make every valid sample a match.
REQ-028 run_cnt and locked SHALL be registered outputs, updated on the same edge as out_valid.

Reset
REQ-029 While rst_n=0, asynchronously and regardless of clk, the block SHALL force: state=IDLE, pattern=0, mask=0, out_valid=0, out_eq=0, out_match=0, run_cnt=0, locked=0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight result, and the block SHALL require a new cfg_load before accepting samples.
REQ-031 After rst_n deassertion, the first clock edge SHALL be a normal functional edge.

Structure
REQ-032 Package xnor_match_pkg SHALL hold the state typedef (IDLE=2'd0, ARMED=2'd1, LOCKED=2'd2) and the default parameter constants.
REQ-033 The per-bit masked XNOR SHALL be a purely combinational sub-module, xnor_bank (parameter WIDTH; inputs a, b, mask; output eq).
REQ-034 All state, counter and output registers SHALL reside in xnor_match_unit.
REQ-035 The unused state encoding 2'd3 SHALL recover to IDLE.

Verification (WIDTH=8, CNT_W=8, THRESH=3)
REQ-036 Reset, then in_valid=1 with in_data=8'hA5 and no cfg_load -> out_valid stays 0, run_cnt=0, locked=0.
REQ-037 Load pattern=8'hA5, mask=8'hFF, then samples A5, A5, A5 on consecutive cycles -> out_match=1 each cycle, run_cnt=1,2,3, and locked=1 with the third result.
REQ-038 While locked, send sample 8'hA4 -> out_eq=8'hFE, out_match=0, run_cnt=0, locked=0.
REQ-039 Load mask=8'h0F with pattern=8'hA5, then send 8'h55 -> out_eq=8'hFF and out_match=1; then send 8'hA4 -> out_eq=8'hFE and out_match=0.
REQ-040 Assert cfg_load and in_valid in the same cycle while run_cnt=2 -> out_valid=0 next cycle, run_cnt=0, state=ARMED.
REQ-041 Hold matching samples for 300 cycles with CNT_W=8 -> run_cnt saturates at 255 and stays there; then pulse rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/xnor_match_pkg.sv
// Shared types and default parameters for the masked XNOR pattern matcher.
package xnor_match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_THRESH = 3;

endpackage

// File: rtl/xnor_match_unit_xnor_bank.sv
// Per-bit masked equality: a bit reads 1 when it matches or is masked out.
module xnor_bank #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] eq
);

  assign eq = ~(a ^ b) | ~mask;

endmodule

// File: rtl/xnor_match_unit.sv
// Masked pattern matcher that counts consecutive matching samples and
// locks once the run reaches THRESH.
module xnor_match_unit
  import xnor_match_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_eq,
  output logic             out_match,
  output logic [CNT_W-1:0] run_cnt,
  output logic             locked
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_p1;
  logic [WIDTH-1:0] pattern_p0;
  logic [WIDTH-1:0] mask_p0;
  logic [WIDTH-1:0] eq_p0;
  logic             match_p0;
  logic [CNT_W-1:0] cnt_inc_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] eq_p1;
  logic             match_p1;
  logic [CNT_W-1:0] run_cnt_p1;

  xnor_bank #(.WIDTH(WIDTH)) u_bank (
    .a    (in_data),
    .b    (pattern_p0),
    .mask (mask_p0),
    .eq   (eq_p0)
  );

  assign match_p0   = &eq_p0;
  assign cnt_inc_p0 = sat_inc(run_cnt_p1);

  // p0 -> p1: compare result, run counter and FSM all update on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1   <= IDLE;
      pattern_p0 <= '0;
      mask_p0    <= '0;
      vld_p1     <= 1'b0;
      eq_p1      <= '0;
      match_p1   <= 1'b0;
      run_cnt_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (cfg_load) begin
        // A load always wins over a coincident sample, which is dropped
        pattern_p0 <= cfg_pattern;
        mask_p0    <= cfg_mask;
        run_cnt_p1 <= '0;
        state_p1   <= ARMED;
      end else begin
        case (state_p1)
          IDLE: begin
          end
          ARMED, LOCKED: begin
            if (in_valid) begin
              vld_p1   <= 1'b1;
              eq_p1    <= eq_p0;
              match_p1 <= match_p0;
              if (match_p0) begin
                run_cnt_p1 <= cnt_inc_p0;
                if (cnt_inc_p0 >= THRESH_C)
                  state_p1 <= LOCKED;
              end else begin
                run_cnt_p1 <= '0;
                state_p1   <= ARMED;
              end
            end
          end
          default: state_p1 <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_eq    = eq_p1;
  assign out_match = match_p1;
  assign run_cnt   = run_cnt_p1;
  assign locked    = (state_p1 == LOCKED);

endmodule

// File: tb/tb_xnor_match_unit.sv
// Directed bench for xnor_match_unit with a per-cycle reference model.
module tb_xnor_match_unit;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 8;
  localparam int THRESH  = 3;
  localparam int RUN_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_load = 1'b0;
  logic [WIDTH-1:0] cfg_pattern = '0;
  logic [WIDTH-1:0] cfg_mask = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_eq;
  logic             out_match;
  logic [CNT_W-1:0] run_cnt;
  logic             locked;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  xnor_match_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_eq      (out_eq),
    .out_match   (out_match),
    .run_cnt     (run_cnt),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pattern bookkeeping and run length as plain integers
  function automatic logic [WIDTH-1:0] masked_eq(input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = m[i] ? (d[i] == p[i]) : 1'b1;
    return r;
  endfunction

  function automatic int next_run(input int r, input logic hit);
    if (!hit) return 0;
    return (r + 1 > RUN_MAX) ? RUN_MAX : r + 1;
  endfunction

  logic             m_loaded = 1'b0;
  logic [WIDTH-1:0] m_pat = '0;
  logic [WIDTH-1:0] m_mask = '0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_eq = '0;
  logic             m_match = 1'b0;
  int               m_run = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loaded <= 1'b0;
      m_pat    <= '0;
      m_mask   <= '0;
      m_valid  <= 1'b0;
      m_eq     <= '0;
      m_match  <= 1'b0;
      m_run    <= 0;
    end else begin
      m_valid <= 1'b0;
      if (cfg_load) begin
        m_loaded <= 1'b1;
        m_pat    <= cfg_pattern;
        m_mask   <= cfg_mask;
        m_run    <= 0;
      end else if (m_loaded && in_valid) begin
        m_valid <= 1'b1;
        m_eq    <= masked_eq(in_data, m_pat, m_mask);
        m_match <= &masked_eq(in_data, m_pat, m_mask);
        m_run   <= next_run(m_run, &masked_eq(in_data, m_pat, m_mask));
      end
    end
  end

  // Locked is exactly "the current run has reached THRESH"
  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      check("model_valid",  64'(out_valid), 64'(m_valid));
      check("model_eq",     64'(out_eq),    64'(m_eq));
      check("model_match",  64'(out_match), 64'(m_match));
      check("model_run",    64'(run_cnt),   64'(m_run));
      check("model_locked", 64'(locked),    64'(m_run >= THRESH));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ld, input logic [7:0] pat, input logic [7:0] msk,
                      input logic vld, input logic [7:0] d);
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_mask    = msk;
    in_valid    = vld;
    in_data     = d;
    cycle();
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] eq,
                            input logic mt, input logic [7:0] rc, input logic lk);
    check({tag, "_valid"},  64'(out_valid), 64'(v));
    check({tag, "_eq"},     64'(out_eq),    64'(eq));
    check({tag, "_match"},  64'(out_match), 64'(mt));
    check({tag, "_run"},    64'(run_cnt),   64'(rc));
    check({tag, "_locked"}, 64'(locked),    64'(lk));
  endtask

  initial begin
    repeat (2) cycle();
    expect_out("reset", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Samples before any load are ignored
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("idle1", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("idle2", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);

    send(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
    expect_out("load", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("run1", 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("run2", 1'b1, 8'hFF, 1'b1, 8'd2, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("run3", 1'b1, 8'hFF, 1'b1, 8'd3, 1'b1);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA4);
    expect_out("unlock", 1'b1, 8'hFE, 1'b0, 8'd0, 1'b0);

    // Low-nibble mask
    send(1'b1, 8'hA5, 8'h0F, 1'b0, 8'h00);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'h55);
    expect_out("mask_hit", 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA4);
    expect_out("mask_miss", 1'b1, 8'hFE, 1'b0, 8'd0, 1'b0);

    // Load colliding with a sample at run_cnt=2
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    check("pre_collide_run", 64'(run_cnt), 64'd2);
    send(1'b1, 8'hA5, 8'hFF, 1'b1, 8'hA5);
    expect_out("collide", 1'b0, 8'hFF, 1'b1, 8'd0, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
    expect_out("armed_after", 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0);
    send(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    expect_out("hold", 1'b0, 8'hFF, 1'b1, 8'd1, 1'b0);

    // All-zero mask accepts anything
    send(1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'h5A);
    expect_out("zero_mask", 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0);

    // THRESH boundary then saturation
    send(1'b1, 8'h3C, 8'hFF, 1'b0, 8'h00);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (i == 1) check("thresh_minus1_locked", 64'(locked), 64'd0);
      if (i == 2) check("thresh_locked", 64'(locked), 64'd1);
      if (i == 254) check("reach_max", 64'(run_cnt), 64'd255);
    end
    expect_out("saturate", 1'b1, 8'hFF, 1'b1, 8'd255, 1'b1);

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    cycle();
    rst_n = 1'b1;
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'h3C);
    expect_out("post_rst", 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    send(1'b1, 8'h3C, 8'hFF, 1'b0, 8'h00);
    send(1'b0, 8'h00, 8'h00, 1'b1, 8'h3C);
    expect_out("reload", 1'b1, 8'hFF, 1'b1, 8'd1, 1'b0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
